// File: rtl/onchip_arb_pkg.sv
// Shared types and default widths for the two-port on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

    function automatic arb_state_t own_state(input port_id_t id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM style requester port: master modport for the requester, slave modport for the arbiter.
interface onchip_mem_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int BE_W   = DEF_BE_W
);
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_arb_grant.sv
// Grant FSM: round-robin with a bounded hold window, or strict port-0 priority
// when ONCHIP_ARB_FIXED_PRIO_EN is defined. Grants are combinational from req.
module onchip_arb_grant
    import onchip_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req0,
    input  logic     req1,
    output logic     grant0,
    output logic     grant1,
    output port_id_t owner_id
);

    arb_state_t state_q, state_d;
    logic       g0, g1;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN

    always_comb begin
        g0      = req0;
        g1      = req1 & ~req0;
        state_d = g0 ? OWN0 : (g1 ? OWN1 : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifndef SYNTHESIS
    a_prio_owner_kept: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == OWN0 && req0) |-> grant0);
`endif

`else

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic       last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic       pick_v;
    port_id_t   pick, own;
    logic       own_req, oth_req;

    always_comb begin
        pick_v  = 1'b0;
        pick    = 1'b0;
        own     = (state_q == OWN1);
        own_req = own ? req1 : req0;
        oth_req = own ? req0 : req1;
        hold_d  = hold_q;
        last_d  = last_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    pick_v = 1'b1;
                    pick   = (req0 & req1) ? ~last_q : req1;
                    hold_d = 4'd1;
                end
            end
            default: begin
                if (own_req && (!oth_req || hold_q < HOLD_MAX)) begin
                    pick_v = 1'b1;
                    pick   = own;
                    hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : 4'(hold_q + 4'd1);
                end else if (oth_req) begin
                    pick_v = 1'b1;
                    pick   = ~own;
                    hold_d = 4'd1;
                end
            end
        endcase
        // Any grant makes the picked port the owner; no grant falls back to IDLE.
        if (pick_v) begin
            state_d = own_state(pick);
            last_d  = pick;
        end else begin
            state_d = IDLE;
        end
        g0 = pick_v & ~pick;
        g1 = pick_v & pick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

`ifndef SYNTHESIS
    a_hold_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        hold_q <= HOLD_MAX);
`endif

`endif

    assign grant0   = g0 & rst_n;
    assign grant1   = g1 & rst_n;
    assign owner_id = grant1;

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(grant0 && grant1));
`endif

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter for the single-port on-chip RAM: RAM mux and read-return tag.
// ONCHIP_ARB_FIXED_PRIO_EN selects strict port-0 priority inside onchip_arb_grant.
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [BE_W-1:0]      mem_byteenable,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_writedata,
    input  logic [DATA_W-1:0]    mem_readdata
);

    logic     req0, req1;
    logic     grant0, grant1;
    port_id_t owner_id;
    logic     rd_v_q, rd_v_d;
    port_id_t rd_id_q, rd_id_d;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    onchip_arb_grant #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .clk      (clk),
        .rst_n    (reset_n),
        .req0     (req0),
        .req1     (req1),
        .grant0   (grant0),
        .grant1   (grant1),
        .owner_id (owner_id)
    );

    always_comb begin
        mem_chipselect = grant0 | grant1;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (grant0) begin
            mem_write      = m0.write;
            mem_address    = m0.address;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
        end else if (grant1) begin
            mem_write      = m1.write;
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
        end
    end

    assign m0.waitrequest = ~reset_n | (req0 & ~grant0);
    assign m1.waitrequest = ~reset_n | (req1 & ~grant1);

    // A read+write collision counts as a write, so it never tags a read return.
    always_comb begin
        rd_v_d  = (grant0 & m0.read & ~m0.write) | (grant1 & m1.read & ~m1.write);
        rd_id_d = owner_id;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v_q  <= 1'b0;
            rd_id_q <= 1'b0;
        end else begin
            rd_v_q  <= rd_v_d;
            rd_id_q <= rd_id_d;
        end
    end

    assign m0.readdatavalid = rd_v_q & (rd_id_q == 1'b0);
    assign m1.readdatavalid = rd_v_q & (rd_id_q == 1'b1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

`ifndef SYNTHESIS
    a_m0_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(m0.read && m0.write));
    a_m1_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(m1.read && m1.write));
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter with a RAM model and read-return scoreboard.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_HOLD = 4;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset_n;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
    onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

    onchip_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BE_W     (BE_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] ram     [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] ram_q;
    exp_t        sb[$];
    exp_t        e;
    logic        ev0, ev1;
    logic [31:0] ed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: one-cycle read latency, byte-lane writes
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end
    assign mem_readdata = ram_q;

    // Scoreboard: acceptances push expected returns, readdatavalid pops them
    always @(negedge clk) begin
        if (!reset_n) begin
            sb.delete();
        end else begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            ed  = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                e   = sb.pop_front();
                ev0 = (e.port == 0);
                ev1 = (e.port == 1);
                ed  = e.data;
            end
            n_checks++;
            if (m0_if.readdatavalid !== ev0) begin
                n_fail++;
                $display("FAIL sb_rdv0 cyc=%0d got %b exp %b", cyc, m0_if.readdatavalid, ev0);
            end
            n_checks++;
            if (m1_if.readdatavalid !== ev1) begin
                n_fail++;
                $display("FAIL sb_rdv1 cyc=%0d got %b exp %b", cyc, m1_if.readdatavalid, ev1);
            end
            if (ev0 || ev1) begin
                n_checks++;
                if ((ev0 ? m0_if.readdata : m1_if.readdata) !== ed) begin
                    n_fail++;
                    $display("FAIL sb_rdata cyc=%0d got %h exp %h", cyc,
                             ev0 ? m0_if.readdata : m1_if.readdata, ed);
                end
            end
            if ((m0_if.read | m0_if.write) && !m0_if.waitrequest) begin
                if (m0_if.write) begin
                    for (int b = 0; b < 4; b++)
                        if (m0_if.byteenable[b]) ref_mem[m0_if.address][8*b +: 8] = m0_if.writedata[8*b +: 8];
                end else begin
                    sb.push_back('{port: 0, data: ref_mem[m0_if.address], cyc: cyc});
                end
            end
            if ((m1_if.read | m1_if.write) && !m1_if.waitrequest) begin
                if (m1_if.write) begin
                    for (int b = 0; b < 4; b++)
                        if (m1_if.byteenable[b]) ref_mem[m1_if.address][8*b +: 8] = m1_if.writedata[8*b +: 8];
                end else begin
                    sb.push_back('{port: 1, data: ref_mem[m1_if.address], cyc: cyc});
                end
            end
        end
    end

    task automatic set_req(input int p, input logic rd, input logic wr,
                           input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic idle_all();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        idle_all();
        @(negedge clk);
        @(negedge clk); #2;
        reset_n = 1'b1;
    endtask

    // Drives one transaction until accepted, then idles the port on the cycle after.
    task automatic do_access(input int p, input logic rd, input logic wr,
                             input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        int waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        @(posedge clk); #1;
        set_req(p, rd, wr, a, be, d);
        while (!acc && waited < 20) begin
            @(negedge clk);
            acc = (p == 0) ? !m0_if.waitrequest : !m1_if.waitrequest;
            if (!acc) begin
                @(posedge clk); #1;
                waited++;
            end
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL access_timeout port=%0d addr=%h got waitrequest=1 exp accept", p, a);
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_all();
        set_req(0, 1'b1, 1'b0, 14'h0005, 4'hF, '0);
        set_req(1, 1'b0, 1'b1, 14'h0006, 4'hF, 32'h1234_5678);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait got %b%b exp 11", m0_if.waitrequest, m1_if.waitrequest);
        end
        n_checks++;
        if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0) begin
            n_fail++;
            $display("FAIL rst_mem got cs=%b wr=%b addr=%h exp 0 0 0", mem_chipselect, mem_write, mem_address);
        end
        n_checks++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_rdv got %b%b exp 00", m0_if.readdatavalid, m1_if.readdatavalid);
        end
        idle_all();
        @(negedge clk); #2;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b0 || mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle got w=%b%b cs=%b exp 00 0", m0_if.waitrequest, m1_if.waitrequest, mem_chipselect);
        end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b1
            || mem_address !== 14'h0010 || mem_writedata !== 32'hDEAD_BEEF || mem_byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL basic_wr got w=%b cs=%b wr=%b a=%h d=%h be=%h exp 0 1 1 0010 deadbeef f",
                     m0_if.waitrequest, mem_chipselect, mem_write, mem_address, mem_writedata, mem_byteenable);
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_rd got w=%b%b wr=%b exp 00 0", m0_if.waitrequest, m1_if.waitrequest, mem_write);
        end
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
        n_checks++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEAD_BEEF || m1_if.readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ret got v0=%b d=%h v1=%b exp 1 deadbeef 0",
                     m0_if.readdatavalid, m0_if.readdata, m1_if.readdatavalid);
        end
        @(negedge clk);
        n_checks++;
        if (m0_if.readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse got %b exp 0", m0_if.readdatavalid);
        end
    endtask

    task automatic test_byteenable();
        do_access(0, 1'b0, 1'b1, 14'h0020, 4'hF, 32'hAAAA_AAAA);
        do_access(0, 1'b0, 1'b1, 14'h0020, 4'h3, 32'h1122_3344);
        do_access(0, 1'b1, 1'b0, 14'h0020, 4'hF, '0);
        @(negedge clk);
        n_checks++;
        if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hAAAA_3344) begin
            n_fail++;
            $display("FAIL be_merge got v=%b d=%h exp 1 aaaa3344", m0_if.readdatavalid, m0_if.readdata);
        end
        do_access(1, 1'b0, 1'b1, 14'h0021, 4'hC, 32'h5566_7788);
        do_access(1, 1'b1, 1'b0, 14'h0021, 4'hF, '0);
        @(negedge clk);
    endtask

`ifndef ONCHIP_ARB_FIXED_PRIO_EN
    task automatic test_round_robin();
        logic [13:0] a0, a1;
        logic        acc0, acc1;
        int          exp_g;
        apply_reset();
        a0 = 14'h0100;
        a1 = 14'h0200;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, a1, 4'hF, '0);
        for (int k = 0; k < 4 * MAX_HOLD; k++) begin
            exp_g = (k / MAX_HOLD) % 2;
            @(negedge clk);
            acc0 = !m0_if.waitrequest;
            acc1 = !m1_if.waitrequest;
            n_checks++;
            if (m0_if.waitrequest !== (exp_g != 0) || m1_if.waitrequest !== (exp_g == 0)) begin
                n_fail++;
                $display("FAIL rr_grant k=%0d got w=%b%b exp grant to port %0d",
                         k, m0_if.waitrequest, m1_if.waitrequest, exp_g);
            end
            n_checks++;
            if (mem_address !== ((exp_g != 0) ? a1 : a0)) begin
                n_fail++;
                $display("FAIL rr_addr k=%0d got %h exp %h", k, mem_address, (exp_g != 0) ? a1 : a0);
            end
            @(posedge clk); #1;
            if (acc0) a0 = a0 + 14'd1;
            if (acc1) a1 = a1 + 14'd1;
            set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
            set_req(1, 1'b1, 1'b0, a1, 4'hF, '0);
        end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_owner_drop();
        logic [13:0] a0, a1;
        logic        acc0, acc1;
        apply_reset();
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 14'h0300, 4'hF, '0);
        @(negedge clk);
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 14'h0301, 4'hF, '0);
        set_req(0, 1'b1, 1'b0, 14'h0380, 4'hF, '0);
        @(negedge clk);
        n_checks++;
        if (m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold got w=%b%b exp 10", m0_if.waitrequest, m1_if.waitrequest);
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0 || mem_address !== 14'h0380) begin
            n_fail++;
            $display("FAIL drop_switch got w0=%b a=%h exp 0 0380", m0_if.waitrequest, mem_address);
        end
        a0 = 14'h0381;
        a1 = 14'h0302;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, a1, 4'hF, '0);
        // m0 already holds one grant, so MAX_HOLD-1 more before m1 returns
        for (int k = 0; k < MAX_HOLD; k++) begin
            @(negedge clk);
            acc0 = !m0_if.waitrequest;
            acc1 = !m1_if.waitrequest;
            n_checks++;
            if (acc0 !== (k < MAX_HOLD - 1) || acc1 !== (k == MAX_HOLD - 1)) begin
                n_fail++;
                $display("FAIL drop_window k=%0d got acc=%b%b exp %b%b", k, acc0, acc1,
                         (k < MAX_HOLD - 1), (k == MAX_HOLD - 1));
            end
            @(posedge clk); #1;
            if (acc0) a0 = a0 + 14'd1;
            if (acc1) a1 = a1 + 14'd1;
            set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
            set_req(1, 1'b1, 1'b0, a1, 4'hF, '0);
        end
        idle_all();
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 14'h0030, 4'hF, '0);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_accept got %b exp 0", m0_if.waitrequest);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        idle_all();
        @(negedge clk);
        n_checks++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0 || mem_chipselect !== 1'b0
            || m0_if.waitrequest !== 1'b1 || m1_if.waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst got v=%b%b cs=%b w=%b%b exp 00 0 11", m0_if.readdatavalid,
                     m1_if.readdatavalid, mem_chipselect, m0_if.waitrequest, m1_if.waitrequest);
        end
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m0_if.readdatavalid !== 1'b0 || m1_if.readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drop got %b%b exp 00", m0_if.readdatavalid, m1_if.readdatavalid);
        end
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 14'h0031, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, 14'h0032, 4'hF, '0);
        @(negedge clk);
        n_checks++;
        if (m0_if.waitrequest !== 1'b0 || m1_if.waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_tie got w=%b%b exp 01", m0_if.waitrequest, m1_if.waitrequest);
        end
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
    endtask

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [13:0] a0;
        apply_reset();
        a0 = 14'h0400;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
        set_req(1, 1'b1, 1'b0, 14'h0480, 4'hF, '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (m1_if.waitrequest !== 1'b1 || m0_if.waitrequest !== 1'b0) begin
                n_fail++;
                $display("FAIL prio_hold k=%0d got w=%b%b exp 01", k, m0_if.waitrequest, m1_if.waitrequest);
            end
            @(posedge clk); #1;
            a0 = a0 + 14'd1;
            set_req(0, 1'b1, 1'b0, a0, 4'hF, '0);
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        n_checks++;
        if (m1_if.waitrequest !== 1'b0 || mem_address !== 14'h0480) begin
            n_fail++;
            $display("FAIL prio_release got w1=%b a=%h exp 0 0480", m1_if.waitrequest, mem_address);
        end
        @(posedge clk); #1;
        idle_all();
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200us");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i]     = 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0103);
            ref_mem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0103);
        end
        reset_n = 1'b0;
        idle_all();
        test_reset();
        test_basic();
        test_byteenable();
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_owner_drop();
`endif
        test_reset_mid_read();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Shares the 32-bit single-port on-chip RAM (14-bit word address, 4-bit byteenable, unregistered q, one-cycle read latency) between two Avalon-MM-style requesters, m0 and m1. It sits between the two requesters and the RAM's s1 port.
- Grants one transaction per cycle with zero-wait acceptance.
- Round-robin with a bounded hold window.
- Returns read data with a per-port readdatavalid one cycle after acceptance.

Parameters:
- ADDR_W, 14, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- MAX_HOLD, 4, max consecutive grants to the current owner while the other port waits; range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mX_address  in  ADDR_W  requester X word address (X = 0, 1)
- mX_byteenable  in  BE_W  requester X byte lanes
- mX_read  in  1  requester X read request
- mX_write  in  1  requester X write request
- mX_writedata  in  DATA_W  requester X write data
- mX_waitrequest  out  1  request not accepted this cycle
- mX_readdata  out  DATA_W  read data, valid with mX_readdatavalid
- mX_readdatavalid  out  1  one-cycle pulse, read data valid
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
Request and handshake
- reqX = mX_read | mX_write.
- read and write asserted together is a protocol violation; treat it as a write and flag it with a sim-only assertion.
- A transaction is accepted in the cycle where reqX=1 and grantX=1.
- mX_waitrequest = reqX & ~grantX (combinational). While reset_n=0, mX_waitrequest=1.
- Requester holds its request stable until waitrequest=0.

RAM drive (combinational mux from the granted port)
- mem_chipselect = grant0|grant1.
- mem_write = granted port's write.
- mem_address, mem_byteenable and mem_writedata come from the granted port; all zero when there is no grant.

Read return
- Registered tag {rd_v, rd_id} captures each accepted read.
- Next cycle: mX_readdatavalid = rd_v & (rd_id==X).
- m0_readdata = m1_readdata = mem_readdata.
- Back-to-back reads give one valid per cycle with no bubbles. Writes produce no readdatavalid.

FSM: IDLE, OWN0, OWN1
- Registers: state, last (last owner, 1 bit), hold_cnt (4 bits).
- IDLE:
  - both request → grant ~last.
  - one requests → grant it.
  - Enter OWNx with hold_cnt=1 and last=x.
- OWNx:
  - reqX & (~reqY | hold_cnt<MAX_HOLD) → grant X; hold_cnt = min(hold_cnt+1, MAX_HOLD).
  - else if reqY → grant Y; go to OWNy with hold_cnt=1 and last=y.
  - else → no grant; go to IDLE.
- Grant is decided and issued in the same cycle; there is no idle arbitration cycle.
- With both ports requesting continuously, X receives MAX_HOLD consecutive grants, then Y receives MAX_HOLD, and so on.
- MAX_HOLD=1 gives strict alternation.

Reset values
- state=IDLE, last=1 (port 0 wins first tie), hold_cnt=0, rd_v=0.
- mX_readdatavalid=0; mem_chipselect=0 and mem_write=0 (no grant).

Boundaries
- Reset asserted mid-read: the pending readdatavalid is dropped, and the requester must reissue.
- Owner drops its request while the other waits: switch in the same cycle.
- hold_cnt saturates at MAX_HOLD while the owner is the only requester.

Optional Feature:
ONCHIP_ARB_FIXED_PRIO_EN
- Defined: port 0 has strict priority.
  - grant0 = req0; grant1 = req1 & ~req0.
  - hold_cnt and last are not implemented; state is tracked only for the assertion monitor.
- Undefined: round-robin with hold window as specified above.
- Read-return path is identical in both builds.

Decomposition:
- Package onchip_arb_pkg:
  - state enum {IDLE, OWN0, OWN1}.
  - 1-bit port-id typedef.
  - default width constants: ADDR_W=14, DATA_W=32, BE_W=4.
- One sub-module, onchip_arb_grant:
  - Contains the FSM, hold counter and grant logic.
  - Inputs: req0, req1. Outputs: grant0, grant1, owner id.
- The top level holds the RAM mux and read-tag register.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x0010 with be=0xF, then reads addr 0x0010 → waitrequest=0 on both; m0_readdatavalid pulses exactly one cycle after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
- Both ports issue continuous reads from cycle 0, MAX_HOLD=4 → grant sequence 0,0,0,0,1,1,1,1,0…; the loser's waitrequest=1 in every non-granted cycle; each readdatavalid is routed to the correct port.
- m0 write be=0x3 data 0x11223344 to an address holding 0xAAAAAAAA → read returns 0xAAAA3344.
- m1 is mid-hold (hold_cnt=2) and drops its request while m0 is waiting → m0 is granted in that same cycle and hold_cnt=1.
- Read accepted, then reset_n pulsed low the next cycle → no readdatavalid on either port; outputs at reset values; the first tie after reset goes to port 0.
- Build with ONCHIP_ARB_FIXED_PRIO_EN, both ports requesting for 10 cycles → m1_waitrequest=1 throughout; m1 is granted on the first cycle after m0 deasserts.
